// File: rtl/w5300_bus_driver.sv
// Cycle-timed access engine for the W5300 direct-address parallel host bus.
// One {dir, addr}/wr_data word per access; all bus controls and results are registered.
module w5300_bus_driver #(
  parameter int T_SETUP    = 1,
  parameter int T_STROBE   = 7,
  parameter int T_HOLD     = 1,
  parameter int T_RECOVERY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [10:0] addr,
  input  logic [15:0] wr_data,
  output logic [15:0] rd_data,
  output logic        op_state,
  output logic        busy,
  output logic        cs_n,
  output logic        rd_n,
  output logic        wr_n,
  output logic [9:0]  bus_addr,
  output logic [15:0] data_out,
  output logic        data_oe,
  input  logic [15:0] data_in
);

  if (T_SETUP < 1 || T_SETUP > 15) begin : g_bad_setup
    $error("T_SETUP must be within 1..15");
  end
  if (T_STROBE < 1 || T_STROBE > 15) begin : g_bad_strobe
    $error("T_STROBE must be within 1..15");
  end
  if (T_HOLD < 1 || T_HOLD > 15) begin : g_bad_hold
    $error("T_HOLD must be within 1..15");
  end
  if (T_RECOVERY < 1 || T_RECOVERY > 15) begin : g_bad_recovery
    $error("T_RECOVERY must be within 1..15");
  end

  localparam logic [3:0] SETUP_LAST    = 4'(T_SETUP - 1);
  localparam logic [3:0] STROBE_LAST   = 4'(T_STROBE - 1);
  localparam logic [3:0] HOLD_LAST     = 4'(T_HOLD - 1);
  localparam logic [3:0] RECOVERY_LAST = 4'(T_RECOVERY - 1);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RECOVER} state_t;

  state_t     state_reg;
  logic [3:0] phase_cnt_reg;
  logic       dir_reg;

  // Every bus output is updated on the edge that enters the phase it belongs to,
  // so pad-facing signals never pass through combinational logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      phase_cnt_reg <= 4'd0;
      dir_reg       <= 1'b0;
      cs_n          <= 1'b1;
      rd_n          <= 1'b1;
      wr_n          <= 1'b1;
      data_oe       <= 1'b0;
      op_state      <= 1'b0;
      busy          <= 1'b0;
      bus_addr      <= 10'd0;
      data_out      <= 16'd0;
      rd_data       <= 16'd0;
    end else begin
      op_state <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req) begin
            dir_reg       <= addr[10];
            bus_addr      <= addr[9:0];
            data_out      <= wr_data;
            cs_n          <= 1'b0;
            data_oe       <= addr[10];
            busy          <= 1'b1;
            phase_cnt_reg <= 4'd0;
            state_reg     <= SETUP;
          end
        end
        SETUP: begin
          if (phase_cnt_reg == SETUP_LAST) begin
            rd_n          <= dir_reg;
            wr_n          <= ~dir_reg;
            phase_cnt_reg <= 4'd0;
            state_reg     <= STROBE;
          end else begin
            phase_cnt_reg <= phase_cnt_reg + 4'd1;
          end
        end
        STROBE: begin
          if (phase_cnt_reg == STROBE_LAST) begin
            // Strobe is still low at this edge, so the sampled data is valid.
            if (!dir_reg) rd_data <= data_in;
            rd_n          <= 1'b1;
            wr_n          <= 1'b1;
            phase_cnt_reg <= 4'd0;
            state_reg     <= HOLD;
          end else begin
            phase_cnt_reg <= phase_cnt_reg + 4'd1;
          end
        end
        HOLD: begin
          if (phase_cnt_reg == HOLD_LAST) begin
            cs_n          <= 1'b1;
            data_oe       <= 1'b0;
            op_state      <= 1'b1;
            phase_cnt_reg <= 4'd0;
            state_reg     <= RECOVER;
          end else begin
            phase_cnt_reg <= phase_cnt_reg + 4'd1;
          end
        end
        RECOVER: begin
          if (phase_cnt_reg == RECOVERY_LAST) begin
            busy          <= 1'b0;
            phase_cnt_reg <= 4'd0;
            state_reg     <= IDLE;
          end else begin
            phase_cnt_reg <= phase_cnt_reg + 4'd1;
          end
        end
        default: begin
          state_reg     <= IDLE;
          phase_cnt_reg <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_w5300_bus_driver.sv
// Bench for w5300_bus_driver: default-timing unit plus a stretched-timing unit,
// per-cycle bus checks and a completion scoreboard keyed on op_state.
module tb_w5300_bus_driver;

  localparam int PS [2] = '{1, 2};
  localparam int PT [2] = '{7, 3};
  localparam int PH [2] = '{1, 2};
  localparam int PR [2] = '{1, 3};

  logic        clk = 1'b0;
  logic        rst;
  logic        req      [2];
  logic [10:0] addr     [2];
  logic [15:0] wr_data  [2];
  logic [15:0] rd_data  [2];
  logic        op_state [2];
  logic        busy     [2];
  logic        cs_n     [2];
  logic        rd_n     [2];
  logic        wr_n     [2];
  logic [9:0]  bus_addr [2];
  logic [15:0] data_out [2];
  logic        data_oe  [2];
  logic [15:0] data_in  [2];

  typedef struct packed {
    logic [9:0]  a;
    logic [15:0] wd;
    logic [15:0] rd;
  } sb_t;

  sb_t q0[$];
  sb_t q1[$];

  logic [9:0]  last_addr [2];
  logic [15:0] last_wd   [2];
  logic [15:0] last_rd   [2];

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  w5300_bus_driver u_dut0 (
    .clk(clk), .rst(rst), .req(req[0]), .addr(addr[0]), .wr_data(wr_data[0]),
    .rd_data(rd_data[0]), .op_state(op_state[0]), .busy(busy[0]), .cs_n(cs_n[0]),
    .rd_n(rd_n[0]), .wr_n(wr_n[0]), .bus_addr(bus_addr[0]), .data_out(data_out[0]),
    .data_oe(data_oe[0]), .data_in(data_in[0])
  );

  w5300_bus_driver #(.T_SETUP(2), .T_STROBE(3), .T_HOLD(2), .T_RECOVERY(3)) u_dut1 (
    .clk(clk), .rst(rst), .req(req[1]), .addr(addr[1]), .wr_data(wr_data[1]),
    .rd_data(rd_data[1]), .op_state(op_state[1]), .busy(busy[1]), .cs_n(cs_n[1]),
    .rd_n(rd_n[1]), .wr_n(wr_n[1]), .bus_addr(bus_addr[1]), .data_out(data_out[1]),
    .data_oe(data_oe[1]), .data_in(data_in[1])
  );

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int u = 0; u < 2; u++) begin
      last_addr[u] = 10'd0;
      last_wd[u]   = 16'd0;
      last_rd[u]   = 16'd0;
    end
  endtask

  // Entered at the start of cycle 0; returns at the start of the IDLE cycle after RECOVER.
  task automatic access(input int u, input bit dir, input logic [9:0] a, input logic [15:0] wd,
                        input logic [15:0] din, input bit hold, input bit mid);
    int s, st, h, tot, opc;
    bit stb, act;
    logic [9:0]  pa;
    logic [15:0] pw;
    sb_t e;
    s   = PS[u];
    st  = PT[u];
    h   = PH[u];
    tot = s + st + h + PR[u];
    opc = s + st + h + 1;
    pa  = last_addr[u];
    pw  = last_wd[u];
    req[u]     = 1'b1;
    addr[u]    = {dir, a};
    wr_data[u] = wd;
    data_in[u] = din;
    last_addr[u] = a;
    last_wd[u]   = wd;
    if (!dir) last_rd[u] = din;
    e = '{a: a, wd: wd, rd: last_rd[u]};
    if (u == 0) q0.push_back(e); else q1.push_back(e);
    $display("access u%0d %s addr=%h wr_data=%h data_in=%h hold=%0d mid=%0d",
             u, dir ? "WR" : "RD", a, wd, din, hold, mid);
    for (int k = 0; k <= tot; k++) begin
      @(negedge clk);
      stb = (k >= s + 1) && (k <= s + st);
      act = (k >= 1) && (k <= s + st + h);
      check_eq($sformatf("u%0d cs_n c%0d", u, k), 16'(cs_n[u]), 16'(!act));
      check_eq($sformatf("u%0d rd_n c%0d", u, k), 16'(rd_n[u]), 16'(!(stb && !dir)));
      check_eq($sformatf("u%0d wr_n c%0d", u, k), 16'(wr_n[u]), 16'(!(stb && dir)));
      check_eq($sformatf("u%0d data_oe c%0d", u, k), 16'(data_oe[u]), 16'(act && dir));
      check_eq($sformatf("u%0d op_state c%0d", u, k), 16'(op_state[u]), 16'(k == opc));
      check_eq($sformatf("u%0d busy c%0d", u, k), 16'(busy[u]), 16'(k >= 1));
      check_eq($sformatf("u%0d bus_addr c%0d", u, k), 16'(bus_addr[u]), 16'((k >= 1) ? a : pa));
      check_eq($sformatf("u%0d data_out c%0d", u, k), data_out[u], (k >= 1) ? wd : pw);
      @(posedge clk);
      #1;
      if (k == 0 && !hold && !mid) req[u] = 1'b0;
      if (mid && (k + 1 == s + 1)) begin
        req[u]     = 1'b0;
        addr[u]    = ~addr[u];
        wr_data[u] = ~wr_data[u];
      end
    end
  endtask

  // Scoreboard: every completion pulse must match the oldest outstanding access.
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (op_state[u] === 1'b1) begin
        if ((u == 0 && q0.size() == 0) || (u == 1 && q1.size() == 0)) begin
          check_eq($sformatf("u%0d op_unexpected", u), 16'd1, 16'd0);
        end else begin
          sb_t e;
          e = (u == 0) ? q0.pop_front() : q1.pop_front();
          check_eq($sformatf("u%0d sb bus_addr", u), 16'(bus_addr[u]), 16'(e.a));
          check_eq($sformatf("u%0d sb data_out", u), data_out[u], e.wd);
          check_eq($sformatf("u%0d sb rd_data", u), rd_data[u], e.rd);
        end
      end
    end
  end

  initial begin
    int opcnt;
    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      req[u] = 1'b0; addr[u] = 11'd0; wr_data[u] = 16'd0; data_in[u] = 16'd0;
    end
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check_eq($sformatf("u%0d rst cs_n", u), 16'(cs_n[u]), 16'd1);
      check_eq($sformatf("u%0d rst rd_n", u), 16'(rd_n[u]), 16'd1);
      check_eq($sformatf("u%0d rst wr_n", u), 16'(wr_n[u]), 16'd1);
      check_eq($sformatf("u%0d rst data_oe", u), 16'(data_oe[u]), 16'd0);
      check_eq($sformatf("u%0d rst busy", u), 16'(busy[u]), 16'd0);
      check_eq($sformatf("u%0d rst op_state", u), 16'(op_state[u]), 16'd0);
      check_eq($sformatf("u%0d rst rd_data", u), rd_data[u], 16'd0);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;

    access(0, 1'b1, 10'h000, 16'h0001, 16'hdead, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    access(0, 1'b0, 10'h3fe, 16'h1234, 16'h5300, 1'b0, 1'b0);
    access(0, 1'b1, 10'h0aa, 16'hcafe, 16'h1111, 1'b0, 1'b0);
    access(0, 1'b1, 10'h000, 16'h1111, 16'h0000, 1'b1, 1'b0);
    access(0, 1'b1, 10'h002, 16'h2222, 16'h0000, 1'b0, 1'b0);
    access(0, 1'b1, 10'h123, 16'h4567, 16'h0000, 1'b0, 1'b1);

    // Reset in cycle 5 of a write, mid-strobe.
    @(posedge clk);
    #1;
    req[0] = 1'b1; addr[0] = {1'b1, 10'h155}; wr_data[0] = 16'hbeef;
    $display("access u0 WR addr=155 wr_data=beef aborted by reset in cycle 5");
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) req[0] = 1'b0;
    end
    check_eq("abort wr_n before rst", 16'(wr_n[0]), 16'd0);
    #1 rst = 1'b1;
    #1;
    check_eq("abort wr_n", 16'(wr_n[0]), 16'd1);
    check_eq("abort cs_n", 16'(cs_n[0]), 16'd1);
    check_eq("abort data_oe", 16'(data_oe[0]), 16'd0);
    check_eq("abort busy", 16'(busy[0]), 16'd0);
    check_eq("abort bus_addr", 16'(bus_addr[0]), 16'd0);
    check_eq("abort data_out", data_out[0], 16'd0);
    check_eq("abort rd_data", rd_data[0], 16'd0);
    clear_model();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    opcnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (op_state[0] === 1'b1) opcnt++;
      check_eq($sformatf("post-abort busy %0d", k), 16'(busy[0]), 16'd0);
    end
    check_eq("post-abort op_state count", 16'(opcnt), 16'd0);
    @(posedge clk);
    #1;
    access(0, 1'b1, 10'h000, 16'h0001, 16'hdead, 1'b0, 1'b0);

    // Stretched timing: read then an immediate accept in the IDLE cycle 11.
    access(1, 1'b0, 10'h010, 16'h0000, 16'h7777, 1'b1, 1'b0);
    access(1, 1'b1, 10'h011, 16'habcd, 16'h0bad, 1'b0, 1'b0);

    repeat (4) @(posedge clk);
    @(negedge clk);
    check_eq("sb empty u0", 16'(q0.size()), 16'd0);
    check_eq("sb empty u1", 16'(q1.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
